// File: rtl/astar_gscore_table.sv
// A* g-score table: one score per maze cell, with a registered read port,
// raw initialiser writes and a two-state compare-and-write relax engine.
module astar_gscore_table #(
    parameter int CELLS = 100,
    parameter int IDX_W = 7,
    parameter int VAL_W = 7,
    parameter int INF   = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             g_write_en,
    input  logic [IDX_W-1:0] g_write_index,
    input  logic [VAL_W-1:0] g_write_val,
    input  logic             rd_req,
    input  logic [IDX_W-1:0] rd_index,
    output logic [VAL_W-1:0] rd_val,
    output logic             rd_valid,
    input  logic             relax_req,
    input  logic [IDX_W-1:0] relax_index,
    input  logic [VAL_W-1:0] relax_val,
    output logic             relax_busy,
    output logic             relax_done,
    output logic             relax_updated
);

    localparam logic [IDX_W:0]   CELLS_L = CELLS[IDX_W:0];
    localparam logic [VAL_W-1:0] INF_V   = INF[VAL_W-1:0];

    typedef enum logic {S_IDLE, S_CMP} state_t;

    logic [VAL_W-1:0] mem [CELLS];
    state_t           state;
    logic [IDX_W-1:0] cap_idx;
    logic [VAL_W-1:0] cap_val;

    logic             raw_wr;
    logic             rd_in_range;
    logic             cap_in_range;
    logic [VAL_W-1:0] cap_cur;
    logic             relax_wr;

    always_comb begin
        raw_wr       = g_write_en && ({1'b0, g_write_index} < CELLS_L);
        rd_in_range  = {1'b0, rd_index} < CELLS_L;
        cap_in_range = {1'b0, cap_idx} < CELLS_L;
        cap_cur      = cap_in_range ? mem[cap_idx] : INF_V;
        // A raw write to the captured cell in the compare cycle wins outright.
        relax_wr     = (state == S_CMP) && cap_in_range && (cap_val < cap_cur) &&
                       !(g_write_en && (g_write_index == cap_idx));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= INF_V;
            rd_val        <= '0;
            rd_valid      <= 1'b0;
            state         <= S_IDLE;
            cap_idx       <= '0;
            cap_val       <= '0;
            relax_busy    <= 1'b0;
            relax_done    <= 1'b0;
            relax_updated <= 1'b0;
        end else begin
            // Reads sample the array before this edge's writes land.
            rd_valid <= rd_req;
            if (rd_req) rd_val <= rd_in_range ? mem[rd_index] : INF_V;

            if (relax_wr) mem[cap_idx] <= cap_val;
            if (raw_wr)   mem[g_write_index] <= g_write_val;

            case (state)
                S_IDLE: begin
                    relax_done    <= 1'b0;
                    relax_updated <= 1'b0;
                    if (relax_req) begin
                        cap_idx    <= relax_index;
                        cap_val    <= relax_val;
                        relax_busy <= 1'b1;
                        state      <= S_CMP;
                    end
                end
                S_CMP: begin
                    relax_done    <= 1'b1;
                    relax_updated <= relax_wr;
                    relax_busy    <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_astar_gscore_table.sv
// Directed bench for astar_gscore_table: reset fill, read-before-write,
// relax latency/outcomes, raw-write priority, busy-drop and reset abort.
module tb_astar_gscore_table;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       g_write_en;
    logic [6:0] g_write_index;
    logic [6:0] g_write_val;
    logic       rd_req;
    logic [6:0] rd_index;
    logic [6:0] rd_val;
    logic       rd_valid;
    logic       relax_req;
    logic [6:0] relax_index;
    logic [6:0] relax_val;
    logic       relax_busy;
    logic       relax_done;
    logic       relax_updated;

    int checks = 0;
    int errors = 0;

    astar_gscore_table dut (
        .clk(clk), .rst_n(rst_n),
        .g_write_en(g_write_en), .g_write_index(g_write_index), .g_write_val(g_write_val),
        .rd_req(rd_req), .rd_index(rd_index), .rd_val(rd_val), .rd_valid(rd_valid),
        .relax_req(relax_req), .relax_index(relax_index), .relax_val(relax_val),
        .relax_busy(relax_busy), .relax_done(relax_done), .relax_updated(relax_updated)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one read and check the returned value on the following cycle.
    task automatic read_chk(input string tag, input logic [6:0] idx, input logic [6:0] exp);
        rd_req   = 1'b1;
        rd_index = idx;
        tick();
        rd_req   = 1'b0;
        check({tag, "_vld"}, {31'd0, rd_valid}, 32'd1);
        check(tag, {25'd0, rd_val}, {25'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; g_write_en = 1'b0; g_write_index = '0; g_write_val = '0;
        rd_req = 1'b0; rd_index = '0; relax_req = 1'b0; relax_index = '0; relax_val = '0;
        tick(); tick();
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_val", {25'd0, rd_val}, 32'd0);
        check("rst_busy", {31'd0, relax_busy}, 32'd0);
        check("rst_done", {31'd0, relax_done}, 32'd0);
        check("rst_updated", {31'd0, relax_updated}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: reset fill and out-of-range read
        read_chk("rd0", 7'd0, 7'd127);
        read_chk("rd42", 7'd42, 7'd127);
        read_chk("rd99", 7'd99, 7'd127);
        read_chk("rd100", 7'd100, 7'd127);
        tick();
        check("rd_idle_vld", {31'd0, rd_valid}, 32'd0);
        check("rd_idle_hold", {25'd0, rd_val}, 32'd127);

        // 2: read-before-write on the same index
        g_write_en = 1'b1; g_write_index = 7'd90; g_write_val = 7'd0;
        rd_req = 1'b1; rd_index = 7'd90;
        tick();
        g_write_en = 1'b0; rd_req = 1'b0;
        check("rbw_old", {25'd0, rd_val}, 32'd127);
        read_chk("rbw_new", 7'd90, 7'd0);

        // 3: relax latency and outcomes
        relax_req = 1'b1; relax_index = 7'd5; relax_val = 7'd12;
        tick();
        relax_req = 1'b0;
        check("rx5_busy", {31'd0, relax_busy}, 32'd1);
        check("rx5_nodone", {31'd0, relax_done}, 32'd0);
        tick();
        check("rx5_done", {31'd0, relax_done}, 32'd1);
        check("rx5_upd", {31'd0, relax_updated}, 32'd1);
        check("rx5_busy0", {31'd0, relax_busy}, 32'd0);
        tick();
        check("rx5_pulse", {31'd0, relax_done}, 32'd0);
        read_chk("rx5_rd", 7'd5, 7'd12);

        relax_req = 1'b1; relax_index = 7'd5; relax_val = 7'd12;
        tick(); relax_req = 1'b0; tick();
        check("rx5_eq_done", {31'd0, relax_done}, 32'd1);
        check("rx5_eq_upd", {31'd0, relax_updated}, 32'd0);
        relax_req = 1'b1; relax_index = 7'd5; relax_val = 7'd20;
        tick(); relax_req = 1'b0; tick();
        check("rx5_gt_done", {31'd0, relax_done}, 32'd1);
        check("rx5_gt_upd", {31'd0, relax_updated}, 32'd0);
        read_chk("rx5_keep", 7'd5, 7'd12);

        // 4: raw write to the same index during compare wins
        relax_req = 1'b1; relax_index = 7'd7; relax_val = 7'd3;
        tick();
        relax_req = 1'b0;
        g_write_en = 1'b1; g_write_index = 7'd7; g_write_val = 7'd50;
        tick();
        g_write_en = 1'b0;
        check("rx7_done", {31'd0, relax_done}, 32'd1);
        check("rx7_upd", {31'd0, relax_updated}, 32'd0);
        read_chk("rx7_rd", 7'd7, 7'd50);

        // different indices both write in the same cycle
        relax_req = 1'b1; relax_index = 7'd8; relax_val = 7'd4;
        tick();
        relax_req = 1'b0;
        g_write_en = 1'b1; g_write_index = 7'd20; g_write_val = 7'd33;
        tick();
        g_write_en = 1'b0;
        check("rx8_upd", {31'd0, relax_updated}, 32'd1);
        read_chk("rx8_rd", 7'd8, 7'd4);
        read_chk("raw20_rd", 7'd20, 7'd33);

        // 5: relax_req held high, only requests seen while idle are taken
        for (int k = 1; k <= 6; k++) begin
            relax_req = 1'b1; relax_index = 7'(k); relax_val = 7'(k + 10);
            tick();
            check($sformatf("hold%0d_busy", k), {31'd0, relax_busy}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("hold%0d_done", k), {31'd0, relax_done}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        relax_req = 1'b0;
        tick();
        read_chk("hold_rd1", 7'd1, 7'd11);
        read_chk("hold_rd2", 7'd2, 7'd127);
        read_chk("hold_rd3", 7'd3, 7'd13);
        read_chk("hold_rd4", 7'd4, 7'd127);
        read_chk("hold_rd5", 7'd5, 7'd12);
        read_chk("hold_rd6", 7'd6, 7'd127);

        // 6: reset during compare abandons the relax
        relax_req = 1'b1; relax_index = 7'd9; relax_val = 7'd1;
        tick();
        relax_req = 1'b0;
        check("ab_busy", {31'd0, relax_busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("ab_done", {31'd0, relax_done}, 32'd0);
        check("ab_busy0", {31'd0, relax_busy}, 32'd0);
        tick();
        check("ab_nodone", {31'd0, relax_done}, 32'd0);
        read_chk("ab_rd9", 7'd9, 7'd127);
        read_chk("ab_rd90", 7'd90, 7'd127);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
